// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port between instruction fetch (I) and load/store (D).
// D wins ties unless D has been granted MAX_STREAK times in a row while I was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  output logic                stall
);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t              state_q;
  logic [3:0]          streak_q, streak_d;
  logic                owner_d_q;
  logic                req_valid_q, req_rw_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_wdata_q;
  logic [DATA_W/8-1:0] req_wmask_q;
  logic                i_ack_q, d_ack_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;
  logic                i_elig, d_elig, grant_i;

  // A requester in its ack cycle still holds req; masking it avoids re-granting a finished request.
  always_comb begin
    i_elig  = i_req & ~i_ack_q;
    d_elig  = d_req & ~d_ack_q;
    grant_i = i_elig & (~d_elig | (streak_q == STREAK_MAX));
    if (grant_i)     streak_d = '0;
    else if (i_elig) streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
    else             streak_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      owner_d_q   <= 1'b0;
      req_valid_q <= 1'b0;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: if (i_elig | d_elig) begin
          owner_d_q   <= ~grant_i;
          req_valid_q <= 1'b1;
          req_rw_q    <= ~grant_i & d_we;
          req_addr_q  <= grant_i ? i_addr : d_addr;
          req_wdata_q <= grant_i ? '0 : d_wdata;
          req_wmask_q <= grant_i ? '0 : d_wmask;
          streak_q    <= streak_d;
          state_q     <= ISSUE;
        end
        ISSUE: if (mem_req_ready) begin
          req_valid_q <= 1'b0;
          // Stores complete on acceptance; only D issues stores.
          if (req_rw_q) begin
            d_ack_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= WAIT_RESP;
          end
        end
        WAIT_RESP: if (mem_resp_valid) begin
          if (owner_d_q) begin
            d_rdata_q <= mem_resp_rdata;
            d_ack_q   <= 1'b1;
          end else begin
            i_rdata_q <= mem_resp_rdata;
            i_ack_q   <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall         = i_elig | d_elig;
  assign i_ack         = i_ack_q;
  assign d_ack         = d_ack_q;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_rw    = req_rw_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;
endmodule
